// File: rtl/spi_flash_sequencer_if.sv
// rtl/spi_flash_sequencer_if.sv - CSR command/status bus of the SPI flash byte sequencer
interface spi_flash_sequencer_if;
  logic        sysCSRstrobe;
  logic [31:0] sysGPIO_OUT;
  logic [31:0] sysStatus;

  modport master (output sysCSRstrobe, output sysGPIO_OUT, input sysStatus);
  modport slave  (input sysCSRstrobe, input sysGPIO_OUT, output sysStatus);
endinterface

// File: rtl/spi_flash_sequencer.sv
// rtl/spi_flash_sequencer.sv - mode-0 SPI flash byte sequencer driven by a CSR command word
module spi_flash_sequencer #(
  parameter int    CLK_DIV = 4,
  parameter string DEBUG   = "false"
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  spi_flash_sequencer_if.slave        csr,
  output logic                        spiFlashClk,
  output logic                        spiFlashMOSI,
  output logic                        spiFlashCS_B,
  input  logic                        spiFlashMISO
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} stateT;

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
  localparam bit unusedDebug = (DEBUG == "true");

  stateT      state;
  logic [7:0] halfCnt;
  logic [2:0] bitCnt;
  logic [7:0] txShift;
  logic [7:0] rxShift;
  logic [7:0] rxData;
  logic       lastByte;
  logic       busy;
  logic       err;

  (* mark_debug = DEBUG *) logic clkQ;
  (* mark_debug = DEBUG *) logic mosiQ;
  (* mark_debug = DEBUG *) logic csBQ;
  (* mark_debug = DEBUG *) logic misoPin;

  logic       cmdGo;
  logic       cmdLast;
  logic       cmdClrErr;
  logic       cmdAbort;
  logic [7:0] cmdTx;
  logic       errSet;
  logic       halfDone;
  wire        unusedCmdBits = &{1'b0, csr.sysGPIO_OUT[31:12]};

  assign misoPin   = spiFlashMISO;
  assign cmdTx     = csr.sysGPIO_OUT[7:0];
  assign cmdGo     = csr.sysCSRstrobe & csr.sysGPIO_OUT[8];
  assign cmdLast   = csr.sysGPIO_OUT[9];
  assign cmdClrErr = csr.sysCSRstrobe & csr.sysGPIO_OUT[10];
  assign cmdAbort  = csr.sysCSRstrobe & csr.sysGPIO_OUT[11];
  // An abort in the same strobe swallows the GO, so it can never count as an overrun.
  assign errSet    = cmdGo & ~cmdAbort & busy;
  assign halfDone  = (halfCnt == 8'd0);

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state    <= IDLE;
      halfCnt  <= 8'd0;
      bitCnt   <= 3'd0;
      txShift  <= 8'd0;
      rxShift  <= 8'd0;
      rxData   <= 8'd0;
      lastByte <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      clkQ     <= 1'b0;
      mosiQ    <= 1'b0;
      csBQ     <= 1'b1;
    end else begin
      err <= errSet | (err & ~cmdClrErr);
      if (cmdAbort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        halfCnt <= 8'd0;
        bitCnt  <= 3'd0;
        clkQ    <= 1'b0;
        mosiQ   <= 1'b0;
        csBQ    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cmdGo) begin
              state    <= SETUP;
              busy     <= 1'b1;
              csBQ     <= 1'b0;
              clkQ     <= 1'b0;
              mosiQ    <= cmdTx[7];
              txShift  <= cmdTx;
              lastByte <= cmdLast;
              halfCnt  <= HALF_LOAD;
              bitCnt   <= 3'd0;
            end
          end
          SETUP: begin
            if (halfDone) begin
              state   <= HIGH;
              clkQ    <= 1'b1;
              halfCnt <= HALF_LOAD;
            end else begin
              halfCnt <= halfCnt - 8'd1;
            end
          end
          HIGH: begin
            if (halfDone) begin
              // Sample MISO at the end of the high phase, then present the next bit.
              state   <= LOW;
              clkQ    <= 1'b0;
              rxShift <= {rxShift[6:0], spiFlashMISO};
              txShift <= {txShift[6:0], 1'b0};
              mosiQ   <= txShift[6];
              halfCnt <= HALF_LOAD;
            end else begin
              halfCnt <= halfCnt - 8'd1;
            end
          end
          LOW: begin
            if (halfDone) begin
              halfCnt <= HALF_LOAD;
              if (bitCnt == 3'd7) begin
                state  <= IDLE;
                busy   <= 1'b0;
                rxData <= rxShift;
                csBQ   <= lastByte;
              end else begin
                state  <= HIGH;
                clkQ   <= 1'b1;
                bitCnt <= bitCnt + 3'd1;
              end
            end else begin
              halfCnt <= halfCnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spiFlashClk   = clkQ;
  assign spiFlashMOSI  = mosiQ;
  assign spiFlashCS_B  = csBQ;
  assign csr.sysStatus = {18'd0, err, misoPin, mosiQ, csBQ, clkQ, busy, rxData};
endmodule
